// File: rtl/digit_pkg.sv
// Shared widths, payload types and blink FSM states for the multi-digit counter mux.
package digit_pkg;

   localparam int unsigned OFFSET_W = 11;
   localparam int unsigned DIGIT_W  = 4;

   typedef logic [OFFSET_W-1:0] offset_t;
   typedef logic [DIGIT_W-1:0]  digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      HIDE = 2'd2
   } blink_state_t;

   // One selected drawing request as handed to the digit bitmap stage
   typedef struct packed {
      offset_t x_offset;
      offset_t y_offset;
      logic    dr;
      digit_t  digit;
   } digit_sel_t;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_blink_ctrl.sv
// Frame-synchronous blink burst controller: alternates HIDE/SHOW phases for a fixed
// number of frames after each blink_start pulse.
module digit_blink_ctrl
   import digit_pkg::*;
#(
   parameter int unsigned BLINK_PERIOD = 8,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic blink_start,
   output logic hide,
   output logic blinking
);

   localparam int unsigned PHASE_W = cnt_w(BLINK_PERIOD);
   localparam int unsigned FRAME_W = cnt_w(BLINK_FRAMES);
   localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'(BLINK_PERIOD - 1);
   localparam logic [FRAME_W-1:0] FRAME_LOAD = FRAME_W'(BLINK_FRAMES - 1);

   blink_state_t         state, state_nx;
   logic [PHASE_W-1:0]   phase_cnt, phase_nx;
   logic [FRAME_W-1:0]   frame_cnt, frame_nx;

   // State, counters and decoded flags; flags track the state being entered
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         phase_cnt <= '0;
         frame_cnt <= '0;
         hide      <= 1'b0;
         blinking  <= 1'b0;
      end else begin
         state     <= state_nx;
         phase_cnt <= phase_nx;
         frame_cnt <= frame_nx;
         hide      <= (state_nx == HIDE);
         blinking  <= (state_nx != IDLE);
      end
   end

   // blink_start has priority over a coincident startOfFrame
   always_comb begin
      state_nx = state;
      phase_nx = phase_cnt;
      frame_nx = frame_cnt;
      if (blink_start) begin
         state_nx = HIDE;
         phase_nx = PHASE_LOAD;
         frame_nx = FRAME_LOAD;
      end else if (startOfFrame && (state != IDLE)) begin
         if (frame_cnt == '0) begin
            state_nx = IDLE;
         end else begin
            frame_nx = frame_cnt - FRAME_W'(1);
            if (phase_cnt == '0) begin
               state_nx = (state == SHOW) ? HIDE : SHOW;
               phase_nx = PHASE_LOAD;
            end else begin
               phase_nx = phase_cnt - PHASE_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/digit_multi_mux.sv
// N-channel digit drawing-request mux with registered output and blink masking.
// Optional leading-zero blanking is enabled by defining DIGIT_LZ_BLANK_EN.
module digit_multi_mux
   import digit_pkg::*;
#(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned BLINK_PERIOD = 8,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     startOfFrame,
   input  logic                     blink_start,
   input  offset_t [N_DIGITS-1:0]   x_offsets,
   input  offset_t [N_DIGITS-1:0]   y_offsets,
   input  logic    [N_DIGITS-1:0]   drs,
   input  digit_t  [N_DIGITS-1:0]   digits,
   output offset_t                  x_offset,
   output offset_t                  y_offset,
   output logic                     dr,
   output digit_t                   digit,
   output logic                     blinking
);

   logic [N_DIGITS-1:0] req_c;
   digit_sel_t          sel_c;
   logic                hide;

   digit_blink_ctrl #(
      .BLINK_PERIOD (BLINK_PERIOD),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .blink_start  (blink_start),
      .hide         (hide),
      .blinking     (blinking)
   );

`ifdef DIGIT_LZ_BLANK_EN
   logic lead_zero_c;

   // Drop requests of zero digits that have only zeros above them; ch0 always draws
   always_comb begin
      req_c       = drs;
      lead_zero_c = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
         lead_zero_c = lead_zero_c & (digits[i] == '0);
         if (lead_zero_c) begin
            req_c[i] = 1'b0;
         end
      end
   end
`else
   assign req_c = drs;
`endif

   // Ascending scan so the highest requesting channel is the last one to win
   always_comb begin
      sel_c = '{x_offset: x_offsets[0], y_offset: y_offsets[0], dr: 1'b0, digit: digits[0]};
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (req_c[i]) begin
            sel_c = '{x_offset: x_offsets[i], y_offset: y_offsets[i], dr: 1'b1, digit: digits[i]};
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         x_offset <= '0;
         y_offset <= '0;
         dr       <= 1'b0;
         digit    <= '0;
      end else begin
         x_offset <= sel_c.x_offset;
         y_offset <= sel_c.y_offset;
         dr       <= sel_c.dr & ~hide;
         digit    <= sel_c.digit;
      end
   end

endmodule

// File: tb/tb_digit_multi_mux.sv
// Self-checking bench for digit_multi_mux: vector table, blink sequences, async reset
// and a randomized run against a frame-counting reference model.
module tb_digit_multi_mux;

   localparam int N  = 4;
   localparam int BP = 2;
   localparam int BF = 6;

   logic                clk = 1'b0;
   logic                resetN;
   logic                startOfFrame;
   logic                blink_start;
   logic [N-1:0][10:0]  x_offsets;
   logic [N-1:0][10:0]  y_offsets;
   logic [N-1:0]        drs;
   logic [N-1:0][3:0]   digits;
   logic [10:0]         x_offset;
   logic [10:0]         y_offset;
   logic                dr;
   logic [3:0]          digit;
   logic                blinking;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        dr;
      logic [3:0]  digit;
   } out_t;

   typedef struct {
      logic [N-1:0]      drs;
      logic [N-1:0][3:0] dg;
      logic [1:0]        exp_ch;
      logic              exp_dr;
      logic [3:0]        exp_digit;
   } vec_t;

   // Expected dr / blinking per frame of one burst (bit k = frame k)
   localparam logic [6:0] BURST_DR = 7'b1001100;
   localparam logic [6:0] BURST_BL = 7'b0111111;

   logic [N-1:0][10:0] fix_x;
   logic [N-1:0][10:0] fix_y;

   bit m_active;
   int m_f;

   digit_multi_mux #(
      .N_DIGITS     (N),
      .BLINK_PERIOD (BP),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .blink_start  (blink_start),
      .x_offsets    (x_offsets),
      .y_offsets    (y_offsets),
      .drs          (drs),
      .digits       (digits),
      .x_offset     (x_offset),
      .y_offset     (y_offset),
      .dr           (dr),
      .digit        (digit),
      .blinking     (blinking)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input out_t exp, input logic exp_bl);
      vectors++;
      if (x_offset !== exp.x || y_offset !== exp.y || dr !== exp.dr ||
          digit !== exp.digit || blinking !== exp_bl) begin
         miscompares++;
         $display("FAIL %s: got x=%0d y=%0d dr=%0b digit=%0d blinking=%0b, expected x=%0d y=%0d dr=%0b digit=%0d blinking=%0b",
                  name, x_offset, y_offset, dr, digit, blinking,
                  exp.x, exp.y, exp.dr, exp.digit, exp_bl);
      end
   endtask

   // Reference selection: the top-most effective request wins, ch0 otherwise
   function automatic out_t ref_mux(input logic [N-1:0] req, input logic [N-1:0][3:0] dg,
                                    input logic [N-1:0][10:0] xs, input logic [N-1:0][10:0] ys);
      out_t o;
      int   win;
      logic [N-1:0] eff;
      eff = req;
`ifdef DIGIT_LZ_BLANK_EN
      for (int i = 1; i < N; i++) begin
         bit allz;
         allz = 1'b1;
         for (int j = i; j < N; j++) if (dg[j] != 4'd0) allz = 1'b0;
         if (allz) eff[i] = 1'b0;
      end
`endif
      win = -1;
      for (int i = N - 1; i >= 0; i--) if (eff[i] && win < 0) win = i;
      o.dr = (win >= 0);
      if (win < 0) win = 0;
      o.x     = xs[win];
      o.y     = ys[win];
      o.digit = dg[win];
      return o;
   endfunction

   // Frame k of a burst is hidden in even-numbered phases
   function automatic bit ref_hidden(input bit active, input int f);
      return active && (((f / BP) % 2) == 0);
   endfunction

   task automatic run_frames(input string name, input logic [6:0] exp_dr, input logic [6:0] exp_bl);
      out_t e;
      for (int k = 0; k < 7; k++) begin
         repeat (3) tick();
         e = '{x: 11'd10, y: 11'd100, dr: exp_dr[k], digit: 4'd3};
         check($sformatf("%s_frame%0d", name, k), e, exp_bl[k]);
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
      end
   endtask

   initial begin
      vec_t tbl [9];
      out_t e;

      fix_x = {11'd40, 11'd30, 11'd20, 11'd10};
      fix_y = {11'd400, 11'd300, 11'd200, 11'd100};

      tbl[0] = '{4'b0010, {4'd0, 4'd0, 4'd7, 4'd3},   2'd1, 1'b1, 4'd7};
      tbl[1] = '{4'b0101, {4'd1, 4'd2, 4'd3, 4'd4},   2'd2, 1'b1, 4'd2};
      tbl[2] = '{4'b0000, {4'd1, 4'd2, 4'd3, 4'd4},   2'd0, 1'b0, 4'd4};
      tbl[3] = '{4'b1000, {4'd15, 4'd10, 4'd3, 4'd4}, 2'd3, 1'b1, 4'd15};
      tbl[4] = '{4'b0110, {4'd9, 4'd8, 4'd12, 4'd6},  2'd2, 1'b1, 4'd8};
      tbl[5] = '{4'b0001, {4'd0, 4'd0, 4'd0, 4'd5},   2'd0, 1'b1, 4'd5};
`ifdef DIGIT_LZ_BLANK_EN
      tbl[6] = '{4'b1111, {4'd0, 4'd0, 4'd0, 4'd5},   2'd0, 1'b1, 4'd5};
      tbl[7] = '{4'b1111, {4'd0, 4'd0, 4'd0, 4'd0},   2'd0, 1'b1, 4'd0};
      tbl[8] = '{4'b0110, {4'd0, 4'd0, 4'd4, 4'd0},   2'd1, 1'b1, 4'd4};
`else
      tbl[6] = '{4'b1111, {4'd0, 4'd0, 4'd0, 4'd5},   2'd3, 1'b1, 4'd0};
      tbl[7] = '{4'b1111, {4'd0, 4'd0, 4'd0, 4'd0},   2'd3, 1'b1, 4'd0};
      tbl[8] = '{4'b0110, {4'd0, 4'd0, 4'd4, 4'd0},   2'd2, 1'b1, 4'd0};
`endif

      // Reset with live inputs: outputs must hold their reset values
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      blink_start  = 1'b0;
      x_offsets    = fix_x;
      y_offsets    = fix_y;
      drs          = 4'b0010;
      digits       = {4'd0, 4'd0, 4'd7, 4'd3};
      repeat (2) tick();
      check("reset", '0, 1'b0);
      resetN = 1'b1;
      tick();

      for (int v = 0; v < 9; v++) begin
         drs    = tbl[v].drs;
         digits = tbl[v].dg;
         tick();
         e = '{x: fix_x[tbl[v].exp_ch], y: fix_y[tbl[v].exp_ch],
               dr: tbl[v].exp_dr, digit: tbl[v].exp_digit};
         check($sformatf("table%0d", v), e, 1'b0);
      end

      // Full blink burst
      drs    = 4'b0001;
      digits = {4'd0, 4'd0, 4'd0, 4'd3};
      blink_start = 1'b1;
      tick();
      blink_start = 1'b0;
      run_frames("burst", BURST_DR, BURST_BL);

      // Restart mid-burst coinciding with startOfFrame
      blink_start = 1'b1;
      tick();
      blink_start = 1'b0;
      repeat (3) begin
         repeat (3) tick();
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
      end
      blink_start  = 1'b1;
      startOfFrame = 1'b1;
      tick();
      blink_start  = 1'b0;
      startOfFrame = 1'b0;
      run_frames("restart", BURST_DR, BURST_BL);

      // Async reset mid-burst while in the SHOW phase
      blink_start = 1'b1;
      tick();
      blink_start = 1'b0;
      repeat (2) begin
         repeat (3) tick();
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
      end
      tick();
      check("pre_reset_show", '{x: 11'd10, y: 11'd100, dr: 1'b1, digit: 4'd3}, 1'b1);
      resetN = 1'b0;
      #2;
      check("async_reset", '0, 1'b0);
      resetN = 1'b1;
      run_frames("post_reset", 7'h7F, 7'h00);

      // Randomized run against the reference model
      m_active = 1'b0;
      m_f      = 0;
      for (int c = 0; c < 3000; c++) begin
         bit hid;
         for (int i = 0; i < N; i++) begin
            x_offsets[i] = 11'($urandom);
            y_offsets[i] = 11'($urandom);
         end
         drs          = 4'($urandom);
         digits       = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         startOfFrame = ($urandom_range(0, 3) == 0);
         blink_start  = ($urandom_range(0, 59) == 0);
         e   = ref_mux(drs, digits, x_offsets, y_offsets);
         hid = ref_hidden(m_active, m_f);
         if (hid) e.dr = 1'b0;
         if (blink_start) begin
            m_active = 1'b1;
            m_f      = 0;
         end else if (startOfFrame && m_active) begin
            m_f++;
            if (m_f >= BF) m_active = 1'b0;
         end
         tick();
         check("random", e, m_active);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
